// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg: shared constants for the HH.MM.SS scan driver.
// Holds segment codes, digit-slot indices and the BCD 7-seg table.
package seg_scan_display_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam logic [2:0] IDX_H1   = 3'd0;
   localparam logic [2:0] IDX_H0   = 3'd1;
   localparam logic [2:0] IDX_M1   = 3'd2;
   localparam logic [2:0] IDX_M0   = 3'd3;
   localparam logic [2:0] IDX_S1   = 3'd4;
   localparam logic [2:0] IDX_S0   = 3'd5;
   localparam logic [2:0] IDX_LAST = IDX_S0;

   localparam logic [2:0] SEL_RUN  = 3'd4;

   localparam logic [5:0] DIG_FIRST = 6'b10_0000;

   // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
   function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
      logic [6:0] c;
      case (bcd)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = SEG_DASH[6:0];
      endcase
      return c;
   endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: timer core -> display digit/select bus.
// master = timer core (drives), slave = display (reads only).
interface seg_scan_display_if;

   logic       edit_en;
   logic [2:0] sel;
   logic [3:0] h1;
   logic [3:0] h0;
   logic [3:0] m1;
   logic [3:0] m0;
   logic [3:0] s1;
   logic [3:0] s0;

   modport master (
      output edit_en, sel,
      output h1, h0, m1, m0, s1, s0
   );

   modport slave (
      input edit_en, sel,
      input h1, h0, m1, m0, s1, s0
   );

endinterface

// File: rtl/seg_scan_display_decode.sv
// seg7_decode: combinational BCD digit to active-low 7-seg pattern.
// Ports: bcd (4b digit in), seg_n (7b {g..a} out, active-low).
module seg7_decode
   import seg_scan_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   assign seg_n = seg7_code(bcd);

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: 6-digit multiplexed 7-seg driver with edit blink
// and expiry flash. Ports: clk, rst_n, tmr (slave digit/select bus),
// seg_n {dp,g..a} and dig_n (bit5=h1..bit0=s0) active-low, alarm.
module seg_scan_display
   import seg_scan_display_pkg::*;
#(
   parameter int SCAN_DIV      = 50_000,
   parameter int BLINK_DIV     = 12_500_000,
   parameter int ALARM_TOGGLES = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_display_if.slave tmr,
   output logic [7:0]        seg_n,
   output logic [5:0]        dig_n,
   output logic              alarm
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int AW = (ALARM_TOGGLES > 1) ?
                       $clog2(ALARM_TOGGLES) : 1;

   localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
   localparam logic [AW-1:0] ALARM_TC = AW'(ALARM_TOGGLES - 1);

   logic [SW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [23:0]   snap;
   logic [23:0]   live;
   logic [2:0]    sel_q;
   logic [AW-1:0] alarm_cnt;

   logic          scan_tc;
   logic          blink_tc;
   logic          frame_wrap;
   logic          expire;
   logic          alarm_clr;
   logic [3:0]    cur_bcd;
   logic [6:0]    cur_seg;
   logic          dp_on;
   logic          edit_blank;
   logic          flash_blank;
   logic [7:0]    seg_d;
   logic [5:0]    dig_d;

   assign live = {tmr.h1, tmr.h0, tmr.m1,
                  tmr.m0, tmr.s1, tmr.s0};

   assign scan_tc    = (scan_cnt == SCAN_TC);
   assign blink_tc   = (blink_cnt == BLINK_TC);
   assign frame_wrap = scan_tc && (idx == IDX_LAST);

   // Expiry is judged on frame snapshots, so a mid-frame
   // update from the timer can never fire it twice.
   assign expire = frame_wrap && (snap != '0) &&
                   (live == '0) && tmr.edit_en &&
                   (tmr.sel >= SEL_RUN);

   assign alarm_clr = !tmr.edit_en || (tmr.sel != sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= IDX_H1;
         snap     <= '0;
      end else if (scan_tc) begin
         scan_cnt <= '0;
         if (idx == IDX_LAST) begin
            idx  <= IDX_H1;
            snap <= live;
         end else begin
            idx <= idx + 3'd1;
         end
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_tc) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Clear outranks a coincident expiry; a new expiry
   // during the flash restarts the toggle count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm     <= 1'b0;
         alarm_cnt <= '0;
         sel_q     <= '0;
      end else begin
         sel_q <= tmr.sel;
         if (alarm_clr) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
         end else if (expire) begin
            alarm     <= 1'b1;
            alarm_cnt <= '0;
         end else if (alarm && blink_tc) begin
            if (alarm_cnt == ALARM_TC) begin
               alarm     <= 1'b0;
               alarm_cnt <= '0;
            end else begin
               alarm_cnt <= alarm_cnt + AW'(1);
            end
         end
      end
   end

   always_comb begin
      cur_bcd = snap[23:20];
      unique case (1'b1)
         (idx == IDX_H0): cur_bcd = snap[19:16];
         (idx == IDX_M1): cur_bcd = snap[15:12];
         (idx == IDX_M0): cur_bcd = snap[11:8];
         (idx == IDX_S1): cur_bcd = snap[7:4];
         (idx == IDX_S0): cur_bcd = snap[3:0];
         default:         cur_bcd = snap[23:20];
      endcase
   end

   seg7_decode u_dec (
      .bcd   (cur_bcd),
      .seg_n (cur_seg)
   );

   assign dp_on = (idx == IDX_H0) || (idx == IDX_M0);

   assign edit_blank = tmr.edit_en && (tmr.sel <= IDX_M0) &&
                       (idx == tmr.sel) && !phase;

   assign flash_blank = alarm && !phase;

   assign seg_d = (edit_blank || flash_blank) ? SEG_BLANK :
                  {~dp_on, cur_seg};

   assign dig_d = ~(DIG_FIRST >> idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n <= SEG_BLANK;
         dig_n <= 6'h3F;
      end else begin
         seg_n <= seg_d;
         dig_n <= dig_d;
      end
   end

endmodule
